// File: rtl/pipe_chain.sv
// Elastic register chain carrying a WIDTH-bit payload through STAGES valid/ready stages.
// Define PIPE_CHAIN_SKID_EN to add a one-entry skid buffer ahead of stage 0 (registered in_ready).
module pipe_chain #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGES    = 2,
    parameter logic [31:0] NOP_VALUE = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(STAGES+2)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 2);
    localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_VALUE);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES:0]   ready;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    logic              in_xfer;
    logic              out_xfer;
    logic              src_valid;
    logic [WIDTH-1:0]  src_data;

    assign in_xfer   = in_valid && in_ready;
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_xfer  = out_valid && out_ready;
    assign occupancy = occ_q;

    // An empty stage always accepts, which squeezes bubbles out under backpressure.
    always_comb begin
        ready = '0;
        ready[STAGES] = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            ready[i] = !valid_q[i] || ready[i+1];
        end
    end

`ifdef PIPE_CHAIN_SKID_EN
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;

    // in_ready comes from register state only, so out_ready never reaches it.
    assign in_ready = !skid_valid_q && !flush && !rst;

    always_comb begin
        src_valid = skid_valid_q || in_xfer;
        src_data  = skid_valid_q ? skid_data_q : in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP;
        end else if (flush) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP;
        end else if (skid_valid_q && ready[0]) begin
            skid_valid_q <= 1'b0;
        end else if (in_xfer && !ready[0]) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data;
        end
    end
`else
    assign in_ready = ready[0] && !flush && !rst;

    always_comb begin
        src_valid = in_xfer;
        src_data  = in_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                data_q[i] <= NOP;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                data_q[i] <= NOP;
            end
        end else begin
            if (ready[0]) begin
                valid_q[0] <= src_valid;
                if (src_valid) begin
                    data_q[0] <= src_data;
                end
            end
            // Invalid upstream leaves a bubble but keeps the old data in place.
            for (int i = 1; i < int'(STAGES); i++) begin
                if (ready[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus random traffic against a queue model.
module tb_pipe_chain;

    localparam int S = 2;
    localparam int W = 32;
    localparam logic [W-1:0] NOP = 32'h00000013;
`ifdef PIPE_CHAIN_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        flush = 1'b0;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic [W-1:0]                in_data = '0;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    logic [W-1:0]                out_data;
    logic [$clog2(S+2)-1:0]      occupancy;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q [$];

    pipe_chain #(
        .WIDTH(W),
        .STAGES(S),
        .NOP_VALUE(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check handshake/scoreboard, then check occupancy after the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        logic exp_ir;
        logic [W-1:0] head;
        int n;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        n = exp_q.size();
        exp_ir = !fl && ((SKID != 0) ? (n < S + 1) : (n < S || ordy));
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid_while_empty", out_valid && (n == 0), 1'b0);
        if (out_valid && ordy && n > 0) begin
            head = exp_q.pop_front();
            chk("out_data_order", out_data, head);
        end
        if (iv && in_ready && !fl) exp_q.push_back(id);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        chk("occupancy", occupancy, exp_q.size());
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, NOP);
        chk("rst_occupancy", occupancy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream, latency STAGES
        cycle(1'b1, 32'h100, 1'b1, 1'b0);
        chk("stream_ov_e1", out_valid, 1'b0);
        cycle(1'b1, 32'h104, 1'b1, 1'b0);
        chk("stream_ov_e2", out_valid, 1'b1);
        chk("stream_od_e2", out_data, 32'h100);
        cycle(1'b1, 32'h108, 1'b1, 1'b0);
        chk("stream_od_e3", out_data, 32'h104);
        chk("stream_occ_e3", occupancy, 2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_od_e4", out_data, 32'h108);
        chk("stream_occ_e4", occupancy, 1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stream_ov_e5", out_valid, 1'b0);
        chk("empty_holds_last", out_data, 32'h108);

        // Backpressure fill then release
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        chk("bp_full_occ", occupancy, S + SKID);
        chk("bp_head", out_data, 32'hA);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_drained_ov", out_valid, 1'b0);
        chk("bp_drained_last", out_data, 32'hC);

        // Bubble collapse under backpressure
        cycle(1'b1, 32'h1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bubble_occ", occupancy, 2);
        chk("bubble_head", out_data, 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bubble_second_ov", out_valid, 1'b1);
        chk("bubble_second_od", out_data, 32'h2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush a full chain while input is offered
        cycle(1'b1, 32'h20, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, 1'b0, 1'b0);
        cycle(1'b1, 32'h28, 1'b0, 1'b1);
        chk("flush_ov", out_valid, 1'b0);
        chk("flush_od", out_data, NOP);
        chk("flush_occ", occupancy, 0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_28", out_valid, 1'b0);

        // Asynchronous reset between edges
        cycle(1'b1, 32'h30, 1'b0, 1'b0);
        cycle(1'b1, 32'h34, 1'b0, 1'b0);
        chk("prerst_occ", occupancy, 2);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h38;
        #2 rst = 1'b1;
        #1;
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_occ", occupancy, 0);
        chk("arst_od", out_data, NOP);
        chk("arst_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete();

        // Full (stages only): in_ready vs out_ready within one cycle
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 chk("full_ir_ordy0", in_ready, (SKID != 0));
        out_ready = 1'b1;
        #1 chk("full_ir_ordy1", in_ready, 1'b1);
        out_ready = 1'b0;
        #1 chk("full_ir_ordy0b", in_ready, (SKID != 0));
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPE_CHAIN_SKID_EN
        // Skid absorbs a third item; in_ready drops the cycle after
        cycle(1'b1, 32'h50, 1'b0, 1'b0);
        cycle(1'b1, 32'h54, 1'b0, 1'b0);
        cycle(1'b1, 32'h58, 1'b0, 1'b0);
        chk("skid_occ3", occupancy, 3);
        chk("skid_ir_low", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("skid_drained", occupancy, 0);
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("final_occ", occupancy, 0);
        chk("final_ov", out_valid, 1'b0);
        chk("final_model_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
